// File: rtl/dmem_port_arbiter_if.sv
// Bundle between the two requesters, the data memory port and dmem_port_arbiter.
// The master side is the requesters plus the memory; the slave side is the arbiter.
interface dmem_port_arbiter_if #(
  parameter int AW = 32
);
  logic          req0;
  logic          req1;
  logic          we0;
  logic          we1;
  logic          lock0;
  logic          lock1;
  logic [AW-1:0] addr0;
  logic [AW-1:0] addr1;
  logic [31:0]   wdata0;
  logic [31:0]   wdata1;
  logic [2:0]    funct3_0;
  logic [2:0]    funct3_1;
  logic          gnt0;
  logic          gnt1;
  logic          rvalid0;
  logic          rvalid1;
  logic [31:0]   rdata0;
  logic [31:0]   rdata1;
  logic          err0;
  logic          err1;
  logic [AW-1:0] mem_address;
  logic [31:0]   mem_write_data;
  logic [2:0]    mem_funct3;
  logic          mem_write;
  logic          mem_read;
  logic [31:0]   mem_read_data;

  modport master (
    output req0, req1, we0, we1, lock0, lock1, addr0, addr1,
           wdata0, wdata1, funct3_0, funct3_1, mem_read_data,
    input  gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1, err0, err1,
           mem_address, mem_write_data, mem_funct3, mem_write, mem_read
  );

  modport slave (
    input  req0, req1, we0, we1, lock0, lock1, addr0, addr1,
           wdata0, wdata1, funct3_0, funct3_1, mem_read_data,
    output gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1, err0, err1,
           mem_address, mem_write_data, mem_funct3, mem_write, mem_read
  );
endinterface

// File: rtl/dmem_port_arbiter.sv
// Round-robin arbiter with short RMW locks for the single data memory port.
// Optional DMEM_ARB_ALIGN_CHECK_EN: misaligned accesses are granted but not forwarded, and flagged.
//
// state | meaning
// IDLE  | no owner; lone requester wins, contested grant goes to rr pointer
// OWN0  | requester 0 holds a lock; requester 1 blocked
// OWN1  | requester 1 holds a lock; requester 0 blocked
module dmem_port_arbiter #(
  parameter int LOCK_MAX = 4,
  parameter int AW       = 32
) (
  input logic            clk,
  input logic            rst_n,
  dmem_port_arbiter_if.slave bus
);
  localparam int CW = $clog2(LOCK_MAX + 1);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

  state_t        state, state_nxt;
  logic          rr_ptr, rr_ptr_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          gnt0, gnt1, any_gnt;
  logic          sel_we, misaligned, legal_f3;
  logic [AW-1:0] sel_addr, addr_q;
  logic [31:0]   sel_wdata, wdata_q, resp_data;
  logic [2:0]    sel_f3, f3_q;
  logic          rvalid0_q, rvalid1_q, err0_q, err1_q;
  logic [31:0]   rdata0_q, rdata1_q;

  // cnt is the number of grants already given under the current lock, so the
  // grant that would bring it to LOCK_MAX is the last one before release.
  always_comb begin
    gnt0       = 1'b0;
    gnt1       = 1'b0;
    state_nxt  = state;
    rr_ptr_nxt = rr_ptr;
    cnt_nxt    = cnt;
    if (rst_n) begin
      case (state)
        IDLE: begin
          if (bus.req0 && bus.req1) begin
            gnt0       = ~rr_ptr;
            gnt1       = rr_ptr;
            rr_ptr_nxt = ~rr_ptr;
          end else begin
            gnt0 = bus.req0;
            gnt1 = bus.req1;
          end
          if (gnt0 && bus.lock0) begin
            if (LOCK_MAX > 1) begin
              state_nxt = OWN0;
              cnt_nxt   = CW'(1);
            end else begin
              rr_ptr_nxt = 1'b1;
            end
          end else if (gnt1 && bus.lock1) begin
            if (LOCK_MAX > 1) begin
              state_nxt = OWN1;
              cnt_nxt   = CW'(1);
            end else begin
              rr_ptr_nxt = 1'b0;
            end
          end
        end
        OWN0: begin
          if (bus.req0) begin
            gnt0 = 1'b1;
            if (bus.lock0 && (cnt < CW'(LOCK_MAX - 1))) begin
              cnt_nxt = cnt + CW'(1);
            end else begin
              state_nxt  = IDLE;
              cnt_nxt    = '0;
              rr_ptr_nxt = 1'b1;
            end
          end else begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
          end
        end
        OWN1: begin
          if (bus.req1) begin
            gnt1 = 1'b1;
            if (bus.lock1 && (cnt < CW'(LOCK_MAX - 1))) begin
              cnt_nxt = cnt + CW'(1);
            end else begin
              state_nxt  = IDLE;
              cnt_nxt    = '0;
              rr_ptr_nxt = 1'b0;
            end
          end else begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
          end
        end
        default: begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  assign any_gnt   = gnt0 | gnt1;
  assign sel_we    = gnt1 ? bus.we1      : bus.we0;
  assign sel_addr  = gnt1 ? bus.addr1    : bus.addr0;
  assign sel_wdata = gnt1 ? bus.wdata1   : bus.wdata0;
  assign sel_f3    = gnt1 ? bus.funct3_1 : bus.funct3_0;

  always_comb begin
    misaligned = 1'b0;
`ifdef DMEM_ARB_ALIGN_CHECK_EN
    case (sel_f3)
      3'b001, 3'b101: misaligned = sel_addr[0];
      3'b010:         misaligned = (sel_addr[1:0] != 2'b00);
      default:        misaligned = 1'b0;
    endcase
`endif
  end

  always_comb begin
    case (sel_f3)
      3'b000, 3'b001, 3'b010, 3'b100, 3'b101: legal_f3 = 1'b1;
      default:                                legal_f3 = 1'b0;
    endcase
  end

  // Illegal size codes are still forwarded; the memory ignores them, so read data is forced to 0.
  assign resp_data = (!sel_we && legal_f3 && !misaligned) ? bus.mem_read_data : 32'h0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      rr_ptr    <= 1'b0;
      cnt       <= '0;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
      rdata0_q  <= 32'h0;
      rdata1_q  <= 32'h0;
      err0_q    <= 1'b0;
      err1_q    <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= 32'h0;
      f3_q      <= 3'b000;
    end else begin
      state     <= state_nxt;
      rr_ptr    <= rr_ptr_nxt;
      cnt       <= cnt_nxt;
      rvalid0_q <= gnt0;
      rvalid1_q <= gnt1;
      rdata0_q  <= gnt0 ? resp_data : 32'h0;
      rdata1_q  <= gnt1 ? resp_data : 32'h0;
      err0_q    <= gnt0 & misaligned;
      err1_q    <= gnt1 & misaligned;
      if (any_gnt) begin
        addr_q  <= sel_addr;
        wdata_q <= sel_wdata;
        f3_q    <= sel_f3;
      end
    end
  end

  assign bus.gnt0           = gnt0;
  assign bus.gnt1           = gnt1;
  assign bus.rvalid0        = rvalid0_q;
  assign bus.rvalid1        = rvalid1_q;
  assign bus.rdata0         = rdata0_q;
  assign bus.rdata1         = rdata1_q;
  assign bus.err0           = err0_q;
  assign bus.err1           = err1_q;
  assign bus.mem_address    = any_gnt ? sel_addr  : addr_q;
  assign bus.mem_write_data = any_gnt ? sel_wdata : wdata_q;
  assign bus.mem_funct3     = any_gnt ? sel_f3    : f3_q;
  assign bus.mem_write      = any_gnt &  sel_we & ~misaligned;
  assign bus.mem_read       = any_gnt & ~sel_we & ~misaligned;
endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for dmem_port_arbiter with a small byte memory model and a
// per-requester response scoreboard drained by an independent monitor.
module tb_dmem_port_arbiter;
  logic clk;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  dmem_port_arbiter_if #(.AW(32)) bus ();

  dmem_port_arbiter #(.LOCK_MAX(4), .AW(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // byte memory: asynchronous extended read, write applied mid grant cycle
  logic [7:0]  mem [0:1023];
  logic [9:0]  ma0, ma1, ma2, ma3;
  logic [31:0] word;

  always_comb begin
    ma0  = bus.mem_address[9:0];
    ma1  = ma0 + 10'd1;
    ma2  = ma0 + 10'd2;
    ma3  = ma0 + 10'd3;
    word = {mem[ma3], mem[ma2], mem[ma1], mem[ma0]};
    case (bus.mem_funct3)
      3'b000:  bus.mem_read_data = {{24{mem[ma0][7]}}, mem[ma0]};
      3'b001:  bus.mem_read_data = {{16{mem[ma1][7]}}, mem[ma1], mem[ma0]};
      3'b100:  bus.mem_read_data = {24'h0, mem[ma0]};
      3'b101:  bus.mem_read_data = {16'h0, mem[ma1], mem[ma0]};
      default: bus.mem_read_data = word;
    endcase
  end

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
    for (int i = 0; i < 8; i++) mem[i] = 8'(i);
    {mem[19], mem[18], mem[17], mem[16]} = 32'hDEADBEEF;
    {mem[23], mem[22], mem[21], mem[20]} = 32'h12345678;
    forever begin
      @(negedge clk);
      if (bus.mem_write) begin
        case (bus.mem_funct3)
          3'b000: mem[bus.mem_address[9:0]] = bus.mem_write_data[7:0];
          3'b001: begin
            mem[bus.mem_address[9:0]]         = bus.mem_write_data[7:0];
            mem[bus.mem_address[9:0] + 10'd1] = bus.mem_write_data[15:8];
          end
          3'b010: begin
            mem[bus.mem_address[9:0]]         = bus.mem_write_data[7:0];
            mem[bus.mem_address[9:0] + 10'd1] = bus.mem_write_data[15:8];
            mem[bus.mem_address[9:0] + 10'd2] = bus.mem_write_data[23:16];
            mem[bus.mem_address[9:0] + 10'd3] = bus.mem_write_data[31:24];
          end
          default: ;
        endcase
      end
    end
  end

  logic [32:0] q0[$];
  logic [32:0] q1[$];

  task automatic chk(input string nm, input logic [32:0] act, input logic [32:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // monitor: every response pulse must match the oldest expected entry
  initial begin
    logic [32:0] e;
    forever begin
      @(negedge clk);
      if (bus.rvalid0) begin
        if (q0.size() == 0) chk("rsp0_unexpected", {bus.err0, bus.rdata0}, 33'h1_FFFF_FFFF);
        else begin
          e = q0.pop_front();
          chk("rsp0", {bus.err0, bus.rdata0}, e);
        end
      end
      if (bus.rvalid1) begin
        if (q1.size() == 0) chk("rsp1_unexpected", {bus.err1, bus.rdata1}, 33'h1_FFFF_FFFF);
        else begin
          e = q1.pop_front();
          chk("rsp1", {bus.err1, bus.rdata1}, e);
        end
      end
    end
  end

  // one cycle: drive after the edge, check grant (and optionally mem_read) mid-cycle
  task automatic step(input string nm,
                      input logic r0, input logic w0, input logic l0,
                      input logic [31:0] a0, input logic [31:0] d0, input logic [2:0] f0,
                      input logic r1, input logic w1, input logic l1,
                      input logic [31:0] a1, input logic [31:0] d1, input logic [2:0] f1,
                      input logic [1:0] eg, input logic [32:0] ex0, input logic [32:0] ex1,
                      input int mrd);
    bus.req0 = r0; bus.we0 = w0; bus.lock0 = l0; bus.addr0 = a0; bus.wdata0 = d0; bus.funct3_0 = f0;
    bus.req1 = r1; bus.we1 = w1; bus.lock1 = l1; bus.addr1 = a1; bus.wdata1 = d1; bus.funct3_1 = f1;
    @(negedge clk);
    chk({nm, "_gnt"}, {31'h0, bus.gnt1, bus.gnt0}, {31'h0, eg});
    if (mrd >= 0) chk({nm, "_mem_read"}, {32'h0, bus.mem_read}, {32'h0, mrd[0]});
    if (eg[0]) q0.push_back(ex0);
    if (eg[1]) q1.push_back(ex1);
    @(posedge clk);
    #1;
  endtask

  localparam logic [2:0] LB = 3'b000, LH = 3'b001, LW = 3'b010, LBU = 3'b100, LHU = 3'b101;
  localparam logic [32:0] BEEF = {1'b0, 32'hDEADBEEF};
  localparam logic [32:0] W14  = {1'b0, 32'h12345678};
  localparam logic [32:0] Z    = 33'h0;

  initial begin
    rst_n = 1'b0;
    bus.req0 = 1'b0; bus.we0 = 1'b0; bus.lock0 = 1'b0; bus.addr0 = 32'h0; bus.wdata0 = 32'h0; bus.funct3_0 = LW;
    bus.req1 = 1'b0; bus.we1 = 1'b0; bus.lock1 = 1'b0; bus.addr1 = 32'h0; bus.wdata1 = 32'h0; bus.funct3_1 = LW;
    @(posedge clk);
    #1;
    // reset held: no grants, no memory enables even with requests pending
    step("rst_a", 1,0,0, 32'h10,0,LW, 1,0,0, 32'h14,0,LW, 2'b00, Z, Z, 0);
    step("rst_b", 1,0,0, 32'h10,0,LW, 0,0,0, 32'h14,0,LW, 2'b00, Z, Z, 0);
    chk("rst_rvalid", {30'h0, bus.rvalid1, bus.rvalid0, bus.err0}, 33'h0);
    chk("rst_rdata0", {1'b0, bus.rdata0}, 33'h0);
    rst_n = 1'b1;

    // 1: lone load
    step("t1", 1,0,0, 32'h10,0,LW, 0,0,0, 32'h14,0,LW, 2'b01, BEEF, Z, 1);

    // 2: contested, no lock -> alternating
    step("t2_0", 1,0,0, 32'h10,0,LW, 1,0,0, 32'h14,0,LW, 2'b01, BEEF, W14, -1);
    step("t2_1", 1,0,0, 32'h10,0,LW, 1,0,0, 32'h14,0,LW, 2'b10, BEEF, W14, -1);
    step("t2_2", 1,0,0, 32'h10,0,LW, 1,0,0, 32'h14,0,LW, 2'b01, BEEF, W14, -1);
    step("t2_3", 1,0,0, 32'h10,0,LW, 1,0,0, 32'h14,0,LW, 2'b10, BEEF, W14, -1);

    // 3: lock held, forced release after 4 grants
    step("t3_0", 1,0,1, 32'h10,0,LW, 1,0,0, 32'h14,0,LW, 2'b01, BEEF, W14, -1);
    step("t3_1", 1,0,1, 32'h10,0,LW, 1,0,0, 32'h14,0,LW, 2'b01, BEEF, W14, -1);
    step("t3_2", 1,0,1, 32'h10,0,LW, 1,0,0, 32'h14,0,LW, 2'b01, BEEF, W14, -1);
    step("t3_3", 1,0,1, 32'h10,0,LW, 1,0,0, 32'h14,0,LW, 2'b01, BEEF, W14, -1);
    step("t3_4", 1,0,1, 32'h10,0,LW, 1,0,0, 32'h14,0,LW, 2'b10, BEEF, W14, -1);
    step("t3_5", 1,0,1, 32'h10,0,LW, 1,0,0, 32'h14,0,LW, 2'b01, BEEF, W14, -1);
    step("t3_6", 1,0,1, 32'h10,0,LW, 1,0,0, 32'h14,0,LW, 2'b01, BEEF, W14, -1);
    // owner drops its request: lock ends, no grant this cycle, other granted next
    step("t3_7", 0,0,0, 32'h10,0,LW, 1,0,0, 32'h14,0,LW, 2'b00, BEEF, W14, -1);
    step("t3_8", 0,0,0, 32'h10,0,LW, 1,0,0, 32'h14,0,LW, 2'b10, BEEF, W14, -1);

    // 4: store byte then read it back unsigned and signed
    step("t4_sb",  0,0,0, 32'h10,0,LW, 1,1,0, 32'h103,32'h0000_00A5,LB, 2'b10, Z, Z, 0);
    step("t4_lbu", 0,0,0, 32'h10,0,LW, 1,0,0, 32'h103,0,LBU, 2'b10, Z, {1'b0, 32'h0000_00A5}, 1);
    step("t4_lb",  0,0,0, 32'h10,0,LW, 1,0,0, 32'h103,0,LB,  2'b10, Z, {1'b0, 32'hFFFF_FFA5}, -1);
    step("t4_ill", 1,0,0, 32'h10,0,3'b011, 0,0,0, 32'h14,0,LW, 2'b01, Z, Z, -1);

    // 5: reset while OWN0 with cnt=2 and pointer at 1
    step("t5_a", 1,0,1, 32'h10,0,LW, 0,0,0, 32'h14,0,LW, 2'b01, BEEF, W14, -1);
    step("t5_b", 1,0,1, 32'h10,0,LW, 1,0,0, 32'h14,0,LW, 2'b01, BEEF, W14, -1);
    rst_n = 1'b0;
    step("t5_rst", 1,0,1, 32'h10,0,LW, 1,0,0, 32'h14,0,LW, 2'b00, BEEF, W14, 0);
    rst_n = 1'b1;
    step("t5_d", 0,0,0, 32'h10,0,LW, 1,0,0, 32'h14,0,LW, 2'b10, BEEF, W14, -1);
    step("t5_e", 1,0,0, 32'h10,0,LW, 1,0,0, 32'h14,0,LW, 2'b01, BEEF, W14, -1);

    // 6: misaligned word load, then an aligned half load
`ifdef DMEM_ARB_ALIGN_CHECK_EN
    step("t6_lw", 1,0,0, 32'h2,0,LW, 0,0,0, 32'h14,0,LW, 2'b01, {1'b1, 32'h0}, Z, 0);
`else
    step("t6_lw", 1,0,0, 32'h2,0,LW, 0,0,0, 32'h14,0,LW, 2'b01, {1'b0, 32'h0504_0302}, Z, 1);
`endif
    step("t6_lhu", 0,0,0, 32'h2,0,LW, 1,0,0, 32'h2,0,LHU, 2'b10, Z, {1'b0, 32'h0000_0302}, 1);
    step("t6_lh",  0,0,0, 32'h2,0,LW, 1,0,0, 32'h12,0,LH, 2'b10, Z, {1'b0, 32'hFFFF_DEAD}, 1);

    // drain
    step("idle_0", 0,0,0, 32'h0,0,LW, 0,0,0, 32'h0,0,LW, 2'b00, Z, Z, 0);
    step("idle_1", 0,0,0, 32'h0,0,LW, 0,0,0, 32'h0,0,LW, 2'b00, Z, Z, 0);
    chk("q0_drained", 33'(q0.size()), 33'h0);
    chk("q1_drained", 33'(q1.size()), 33'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
